rs485_slave_responder: RTL and testbench

Parametrised half-duplex RS485 multidrop slave for the POEM/PSLV link. It receives 11-bit frames on the bus and recognises its own 9-bit-mode address frame. It then drives a configurable-length response of NUM_BYTES data frames and releases the driver. It replaces the fixed two-byte detector/transmitter pair. Baud generation, mid-bit sampling and frame checking are internal.

---
 rtl/rs485_slave_responder_if.sv | 24 ++
 rtl/rs485_slave_responder.sv | 175 +++++++++++++++++
 tb/tb_rs485_slave_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rs485_slave_responder_if.sv
// rs485_slave_responder_if: bus and status bundle for the RS485 slave responder.
// slave modport (DUT): rx, tx_data in; tx, tx_enable, tx_busy, addr_match, bcast_detect, frame_error, tx_complete out.
// master modport: the same signals seen from the bus / host side.
interface rs485_slave_responder_if #(
  parameter int NUM_BYTES = 2
);
  logic                   rx;
  logic [8*NUM_BYTES-1:0] tx_data;
  logic                   tx;
  logic                   tx_enable;
  logic                   tx_busy;
  logic                   addr_match;
  logic                   bcast_detect;
  logic                   frame_error;
  logic                   tx_complete;
  modport slave (
    input  rx, tx_data,
    output tx, tx_enable, tx_busy, addr_match, bcast_detect, frame_error, tx_complete
  );
  modport master (
    output rx, tx_data,
    input  tx, tx_enable, tx_busy, addr_match, bcast_detect, frame_error, tx_complete
  );
endinterface

// File: rtl/rs485_slave_responder.sv
// rs485_slave_responder: half-duplex RS485 multidrop slave answering its own 9-bit address frame with NUM_BYTES data frames.
// Ports: clk_i (system clock), rst_ni (asynchronous active-low reset), bus (slave modport of rs485_slave_responder_if).
// Optional feature macro RS485_BROADCAST_EN: address 8'hFF is accepted as a broadcast (bcast_detect, no response).
module rs485_slave_responder #(
  parameter int         CLKS_PER_BIT    = 50,
  parameter logic [7:0] SLAVE_ADDR      = 8'h01,
  parameter int         NUM_BYTES       = 2,
  parameter int         TURNAROUND_BITS = 1
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  rs485_slave_responder_if.slave bus
);
  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam int              BW       = $clog2(NUM_BYTES + 1);
  localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]      LEAD_END = 4'(TURNAROUND_BITS == 0 ? 0 : TURNAROUND_BITS - 1);
  localparam logic [BW-1:0]   BYTE_END = BW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} r_state_e;
  typedef enum logic [2:0] {T_IDLE, T_LEAD, T_FRAME, T_TAIL, T_DONE} t_state_e;

  logic [1:0]             sync_q;
  logic                   rx_prev_q;
  r_state_e               r_state_q, r_state_d;
  logic [CW-1:0]          r_cnt_q, r_cnt_d;
  logic [3:0]             r_bit_q, r_bit_d;
  logic [8:0]             r_sh_q, r_sh_d;
  logic                   am_q, am_d;
  logic                   bc_q, bc_d;
  logic                   fe_q, fe_d;
  logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
  t_state_e               t_state_q, t_state_d;
  logic [CW-1:0]          t_cnt_q, t_cnt_d;
  logic [3:0]             t_bit_q, t_bit_d;
  logic [BW-1:0]          t_byte_q, t_byte_d;

  logic        rx_s;
  logic        busy;
  logic        is_bc;
  logic        good;
  logic [7:0]  cur_byte;
  logic [10:0] t_frame;

  assign rx_s = sync_q[1];
  assign busy = am_q | (t_state_q != T_IDLE);
  // Mark set and stop high: a well-formed address frame, whoever it is for.
  assign good = rx_s & r_sh_q[8];

`ifdef RS485_BROADCAST_EN
  assign is_bc = r_sh_q[7:0] == 8'hFF;
`else
  assign is_bc = 1'b0;
`endif

  // Receiver; held idle while transmitting so our own echo is ignored.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q + 1'b1;
    r_bit_d   = r_bit_q;
    r_sh_d    = r_sh_q;
    am_d      = 1'b0;
    bc_d      = 1'b0;
    fe_d      = 1'b0;
    if (busy) begin
      r_state_d = R_IDLE;
      r_cnt_d   = '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          r_cnt_d = '0;
          if (rx_prev_q && !rx_s) r_state_d = R_START;
        end
        R_START: if (r_cnt_q == HALF_END) begin
          r_cnt_d   = '0;
          r_bit_d   = '0;
          r_state_d = rx_s ? R_IDLE : R_BITS;
        end
        R_BITS: if (r_cnt_q == BIT_END) begin
          r_cnt_d   = '0;
          r_sh_d    = {rx_s, r_sh_q[8:1]};
          r_bit_d   = r_bit_q + 1'b1;
          r_state_d = r_bit_q == 4'd8 ? R_STOP : R_BITS;
        end
        R_STOP: if (r_cnt_q == BIT_END) begin
          r_state_d = R_IDLE;
          fe_d      = !rx_s;
          am_d      = good & !is_bc & (r_sh_q[7:0] == SLAVE_ADDR);
          bc_d      = good & is_bc;
        end
        default: r_state_d = R_IDLE;
      endcase
    end
    shadow_d = am_d ? bus.tx_data : shadow_q;
  end

  assign cur_byte = shadow_q[{t_byte_q, 3'b000} +: 8];
  // Bit 0 is the start bit, bit 9 the mark (0 = data), bit 10 the stop bit.
  assign t_frame  = {2'b10, cur_byte, 1'b0};

  // Transmitter
  always_comb begin
    t_state_d = t_state_q;
    t_cnt_d   = t_cnt_q + 1'b1;
    t_bit_d   = t_bit_q;
    t_byte_d  = t_byte_q;
    case (t_state_q)
      T_IDLE: begin
        t_cnt_d  = '0;
        t_bit_d  = '0;
        t_byte_d = '0;
        if (am_q) t_state_d = TURNAROUND_BITS == 0 ? T_FRAME : T_LEAD;
      end
      T_LEAD: if (t_cnt_q == BIT_END) begin
        t_cnt_d   = '0;
        t_bit_d   = t_bit_q == LEAD_END ? 4'd0 : t_bit_q + 1'b1;
        t_state_d = t_bit_q == LEAD_END ? T_FRAME : T_LEAD;
      end
      T_FRAME: if (t_cnt_q == BIT_END) begin
        t_cnt_d = '0;
        t_bit_d = t_bit_q == 4'd10 ? 4'd0 : t_bit_q + 1'b1;
        if (t_bit_q == 4'd10) begin
          t_byte_d  = t_byte_q == BYTE_END ? t_byte_q : t_byte_q + 1'b1;
          t_state_d = t_byte_q == BYTE_END ? T_TAIL : T_FRAME;
        end
      end
      T_TAIL: if (t_cnt_q == BIT_END) t_state_d = T_DONE;
      T_DONE: t_state_d = T_IDLE;
      default: t_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_bit_q   <= '0;
      r_sh_q    <= '0;
      am_q      <= 1'b0;
      bc_q      <= 1'b0;
      fe_q      <= 1'b0;
      shadow_q  <= '0;
      t_state_q <= T_IDLE;
      t_cnt_q   <= '0;
      t_bit_q   <= '0;
      t_byte_q  <= '0;
    end else begin
      sync_q    <= {sync_q[0], bus.rx};
      rx_prev_q <= rx_s;
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_bit_q   <= r_bit_d;
      r_sh_q    <= r_sh_d;
      am_q      <= am_d;
      bc_q      <= bc_d;
      fe_q      <= fe_d;
      shadow_q  <= shadow_d;
      t_state_q <= t_state_d;
      t_cnt_q   <= t_cnt_d;
      t_bit_q   <= t_bit_d;
      t_byte_q  <= t_byte_d;
    end
  end

  assign bus.tx_enable    = (t_state_q == T_LEAD) | (t_state_q == T_FRAME) | (t_state_q == T_TAIL);
  assign bus.tx           = t_state_q == T_FRAME ? t_frame[t_bit_q] : 1'b1;
  assign bus.tx_busy      = busy;
  assign bus.addr_match   = am_q;
  assign bus.bcast_detect = bc_q;
  assign bus.frame_error  = fe_q;
  assign bus.tx_complete  = t_state_q == T_DONE;
endmodule

// File: tb/tb_rs485_slave_responder.sv
// tb_rs485_slave_responder: directed self-checking bench for rs485_slave_responder.
module tb_rs485_slave_responder;
  localparam int CPB = 50;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0, passed = 0, fails = 0;
  int am_cnt = 0, fe_cnt = 0, bc_cnt = 0, tc_cnt = 0, rise_cnt = 0, idle_bad = 0;
  int en_len = 0, last_len = 0;
  int cur_c;
  logic en_prev = 1'b0;
  logic tc_ok = 1'b0;
  logic [23:0] bits = '0;
  int am0, fe0, bc0, tc0, rise0, bad0;
  bit ok;

  rs485_slave_responder_if #(.NUM_BYTES(2)) bus ();
  rs485_slave_responder #(
    .CLKS_PER_BIT(CPB), .SLAVE_ADDR(8'h01), .NUM_BYTES(2), .TURNAROUND_BITS(1)
  ) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign cur_c = en_prev ? en_len : 0;

  always @(negedge clk) begin
    en_prev <= bus.tx_enable;
    if (bus.addr_match) am_cnt <= am_cnt + 1;
    if (bus.frame_error) fe_cnt <= fe_cnt + 1;
    if (bus.bcast_detect) bc_cnt <= bc_cnt + 1;
    if (bus.tx_complete) tc_cnt <= tc_cnt + 1;
    if (!bus.tx_enable && bus.tx !== 1'b1) idle_bad <= idle_bad + 1;
    if (bus.tx_enable) begin
      en_len <= cur_c + 1;
      if (!en_prev) rise_cnt <= rise_cnt + 1;
      if (cur_c % CPB == CPB / 2 && cur_c / CPB < 24) bits[cur_c / CPB] <= bus.tx;
    end else if (en_prev) begin
      last_len <= en_len;
      tc_ok    <= bus.tx_complete;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] resp(input logic [15:0] d);
    logic [23:0] b;
    b = '1;
    for (int k = 0; k < 2; k++) begin
      b[1 + 11*k] = 1'b0;
      for (int i = 0; i < 8; i++) b[2 + 11*k + i] = d[8*k + i];
      b[10 + 11*k] = 1'b0;
    end
    return b;
  endfunction

  task automatic send(input logic [7:0] d, input logic mark, input logic stop);
    logic [10:0] f;
    f = {stop, mark, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      bus.rx = f[i];
      repeat (CPB) @(posedge clk);
    end
    bus.rx = 1'b1;
    repeat (2*CPB) @(posedge clk);
  endtask

  task automatic snap();
    am0 = am_cnt; fe0 = fe_cnt; bc0 = bc_cnt; tc0 = tc_cnt; rise0 = rise_cnt; bad0 = idle_bad;
  endtask

  task automatic resp_check(input string tag, input logic [15:0] d);
    for (int i = 0; i < 3000 && tc_cnt == tc0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_done"}, 32'(tc_cnt != tc0), 1);
    chk({tag, "_am"}, am_cnt - am0, 1);
    chk({tag, "_len"}, last_len, 1200);
    chk({tag, "_tc_first_low"}, tc_ok, 1);
    chk({tag, "_bits"}, bits, resp(d));
    repeat (20) @(posedge clk);
  endtask

  task automatic quiet_check(input string tag, input int fe_exp);
    repeat (100) @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_am"}, am_cnt - am0, 0);
    chk({tag, "_fe"}, fe_cnt - fe0, fe_exp);
    chk({tag, "_en"}, rise_cnt - rise0, 0);
    chk({tag, "_tx_high"}, idle_bad - bad0, 0);
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.tx_data = 16'hA55A;
    #3 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_tx_enable", bus.tx_enable, 0);
    chk("rst_tx_busy", bus.tx_busy, 0);
    chk("rst_addr_match", bus.addr_match, 0);
    chk("rst_bcast", bus.bcast_detect, 0);
    chk("rst_frame_error", bus.frame_error, 0);
    chk("rst_tx_complete", bus.tx_complete, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    snap();
    send(8'h01, 1'b1, 1'b1);
    resp_check("own", 16'hA55A);

    snap();
    send(8'h02, 1'b1, 1'b1);
    send(8'h01, 1'b0, 1'b1);
    quiet_check("reject", 0);

    snap();
    send(8'h01, 1'b1, 1'b0);
    quiet_check("badstop", 1);
    snap();
    send(8'h01, 1'b1, 1'b1);
    resp_check("after_bad", 16'hA55A);

    snap();
    bus.rx = 1'b0;
    repeat (10) @(posedge clk);
    bus.rx = 1'b1;
    quiet_check("false_start", 0);

    snap();
    send(8'h01, 1'b1, 1'b1);
    bus.tx_data = 16'h3CC3;
    for (int i = 0; i < 2000 && en_len < 800; i++) @(negedge clk);
    chk("mid_reached", 32'(en_len >= 800), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", bus.tx, 1);
    chk("mid_rst_tx_enable", bus.tx_enable, 0);
    chk("mid_rst_tx_busy", bus.tx_busy, 0);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_tc", tc_cnt - tc0, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    snap();
    send(8'h01, 1'b1, 1'b1);
    resp_check("after_rst", 16'h3CC3);

    snap();
    send(8'hFF, 1'b1, 1'b1);
    quiet_check("bcast", 0);
`ifdef RS485_BROADCAST_EN
    chk("bcast_pulse", bc_cnt - bc0, 1);
`else
    chk("bcast_pulse", bc_cnt - bc0, 0);
`endif
    snap();
    send(8'h01, 1'b1, 1'b1);
    resp_check("after_bcast", 16'h3CC3);

    chk("tx_high_when_off", idle_bad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
